// File: rtl/sevenseg_pkg.sv
// Shared definitions for the dual seven-segment display path:
// scan states, anode polarity and a small constant helper.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    SHOW_RIGHT     = 2'd0,
    BLANK_TO_LEFT  = 2'd1,
    SHOW_LEFT      = 2'd2,
    BLANK_TO_RIGHT = 2'd3
  } disp_state_t;

  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_mux.sv
// Two-digit keypad shift register plus a time-multiplexed anode scan with
// dead-time blanking, feeding one shared 4-bit bus to the sevenSeg decoder.
module display_mux
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] s,
  output logic       an_left,
  output logic       an_right,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right
);

  localparam int CNT_MAX = max_of(max_of(REFRESH_DIV, BLANK_CYCLES), 2);
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  disp_state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic [3:0] r_digit_left, r_digit_right;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SHOW_RIGHT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // With no blanking the blank states are never entered.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + CW'(1);
    unique case (r_state)
      SHOW_RIGHT: if (r_cnt == SHOW_LAST) begin
        w_next_cnt   = '0;
        w_next_state = NO_BLANK ? SHOW_LEFT : BLANK_TO_LEFT;
      end
      BLANK_TO_LEFT: if (r_cnt == BLANK_LAST) begin
        w_next_cnt   = '0;
        w_next_state = SHOW_LEFT;
      end
      SHOW_LEFT: if (r_cnt == SHOW_LAST) begin
        w_next_cnt   = '0;
        w_next_state = NO_BLANK ? SHOW_RIGHT : BLANK_TO_RIGHT;
      end
      BLANK_TO_RIGHT: if (r_cnt == BLANK_LAST) begin
        w_next_cnt   = '0;
        w_next_state = SHOW_RIGHT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digit_left  <= 4'h0;
      r_digit_right <= 4'h0;
    end else if (key_valid) begin
      r_digit_left  <= r_digit_right;
      r_digit_right <= key_code;
    end
  end

  // Anodes and s depend only on registers; the upcoming digit is already on
  // s during the blank so the decoder has settled when its anode lights.
  always_comb begin
    an_left  = ANODE_OFF;
    an_right = ANODE_OFF;
    s        = r_digit_right;
    unique case (r_state)
      SHOW_RIGHT: an_right = ANODE_ON;
      BLANK_TO_LEFT: s = r_digit_left;
      SHOW_LEFT: begin
        an_left = ANODE_ON;
        s       = r_digit_left;
      end
      BLANK_TO_RIGHT: s = r_digit_right;
    endcase
  end

  assign digit_left  = r_digit_left;
  assign digit_right = r_digit_right;

endmodule

// File: tb/tb_display_mux.sv
// Scoreboarded bench for display_mux: one instance with blanking (4/2) and
// one without (4/0) share clock, reset and key stimulus.
module tb_display_mux;

  localparam int W = 28;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;

  logic [3:0] a_s, a_dl, a_dr, b_s, b_dl, b_dr;
  logic       a_an_l, a_an_r, b_an_l, b_an_r;

  always #5 clk = ~clk;

  display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .s(a_s), .an_left(a_an_l), .an_right(a_an_r),
    .digit_left(a_dl), .digit_right(a_dr)
  );

  display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .s(b_s), .an_left(b_an_l), .an_right(b_an_r),
    .digit_left(b_dl), .digit_right(b_dr)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic [3:0] mdl_l = 4'h0, mdl_r = 4'h0, pend_code = 4'h0;
  logic pend = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at pos %0d: got %h expected %h", name, pos, act, exp);
    end
  endtask

  // Expected outputs from the cycle position since reset release:
  // 4/2 -> period 12 (R 0-3, blank 4-5, L 6-9, blank 10-11); 4/0 -> period 8.
  function automatic logic [W-1:0] expected_vec(input int p, input logic [3:0] l, input logic [3:0] r);
    int pa, pb;
    logic a_l_on, a_r_on, a_sel_l, b_left;
    pa = p % 12;
    pb = p % 8;
    a_l_on  = (pa >= 6) && (pa <= 9);
    a_r_on  = (pa <= 3);
    a_sel_l = (pa >= 4) && (pa <= 9);
    b_left  = (pb >= 4);
    return {~a_l_on, ~a_r_on, (a_sel_l ? l : r), l, r,
            ~b_left, b_left, (b_left ? l : r), l, r};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("anode_overlap_a", {27'd0, a_an_l | a_an_r}, 28'd1);
      check("anode_overlap_b", {27'd0, b_an_l | b_an_r}, 28'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow at pos %0d: got empty queue expected an entry", pos);
      end else begin
        check("scan_vec", {a_an_l, a_an_r, a_s, a_dl, a_dr, b_an_l, b_an_r, b_s, b_dl, b_dr},
              exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic kv, input logic [3:0] kc);
    @(posedge clk);
    #1;
    if (pend) begin
      mdl_l = mdl_r;
      mdl_r = pend_code;
    end
    pos++;
    exp_q.push_back(expected_vec(pos, mdl_l, mdl_r));
    key_valid = kv;
    key_code  = kc;
    pend      = kv;
    pend_code = kc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  // Assert reset between edges and check the response before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #1;
    mon_en    = 1'b0;
    reset     = 1'b0;
    key_valid = 1'b0;
    pend      = 1'b0;
    mdl_l     = 4'h0;
    mdl_r     = 4'h0;
    pos       = 0;
    #1;
    check("rst_an_left",  {27'd0, a_an_l}, 28'd1);
    check("rst_an_right", {27'd0, a_an_r}, 28'd0);
    check("rst_s",        {24'd0, a_s}, 28'd0);
    check("rst_digits",   {20'd0, a_dl, a_dr}, 28'd0);
    check("rst_b_anodes", {26'd0, b_an_l, b_an_r}, 28'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();
    idle(26);

    step(1'b1, 4'hF);
    step(1'b0, 4'h0);
    step(1'b1, 4'h3);
    idle(24);

    while ((pos % 12) != 2) step(1'b0, 4'h0);
    step(1'b1, 4'h8);
    idle(14);

    step(1'b1, 4'h1);
    step(1'b1, 4'h2);
    step(1'b1, 4'h3);
    idle(7);

    apply_reset();
    idle(16);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
